pipe_if_stage: RTL and testbench
================================

Name: pipe_if_stage

Overview:
Instruction-fetch stage of the 5-stage pipelined CPU: owns the PC, addresses the instruction memory and loads the IF/ID pipeline register. Accepts load-use stall requests from the hazard unit and taken-branch/jump redirects from the later stage. Flags end-of-program when the PC leaves the loaded instruction image. Keeps saturating fetch/stall/redirect counters that the bench reads each cycle.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
IM_DEPTH, 32, instruction memory depth in 32-bit words; valid fetch range is PC < IM_DEPTH*4
CNT_WIDTH, 16, width of each performance counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-high
stall_i  input  1  hazard unit: hold PC and IF/ID this cycle
redirect_i  input  1  taken branch/jump: load PC from target, squash IF/ID
target_i  input  32  redirect target byte address
im_addr_o  output  32  instruction memory byte address, equals pc_o
im_data_i  input  32  instruction word, combinational read of im_addr_o
pc_o  output  32  current PC
ifid_instr_o  output  32  IF/ID instruction (0 = NOP)
ifid_pc4_o  output  32  IF/ID PC+4 of that instruction
ifid_valid_o  output  1  IF/ID holds a real instruction
halted_o  output  1  PC is outside the instruction image
fetch_cnt_o  output  CNT_WIDTH  valid instructions loaded into IF/ID
stall_cnt_o  output  CNT_WIDTH  cycles held by stall
redir_cnt_o  output  CNT_WIDTH  redirects taken

Behaviour:
- Single clock domain. All state updates on the rising edge of clk_i. Reset is synchronous, active-high, and sampled at the edge.
- Reset values: pc_o=RESET_PC; ifid_instr_o=0; ifid_pc4_o=0; ifid_valid_o=0; all counters 0. halted_o is derived from pc_o, so it is 0 when RESET_PC is in range.
- Reset mid-operation discards any pending stall or redirect on that edge.
- im_addr_o = pc_o, combinational. The instruction is captured into IF/ID on the same edge it is read, so fetch latency is 1 cycle from PC to IF/ID.
- halted_o = (pc_o >= IM_DEPTH*4), combinational.
- Per-edge priority when rst_i=0:
  1. redirect_i=1: pc <= {target_i[31:2],2'b00} (low bits forced to 0); IF/ID <= bubble (instr=0, pc4=0, valid=0); redir_cnt+1. Redirect overrides stall_i and halted_o, because the branch is older than the stalled instruction.
  2. else stall_i=1: pc, IF/ID and fetch_cnt hold; stall_cnt+1.
  3. else halted_o=1: pc holds; IF/ID <= bubble; no counter changes.
  4. else normal fetch: pc <= pc+4 (mod 2^32); IF/ID <= {im_data_i, pc+4, valid=1}; fetch_cnt+1.
- A fetched word of 0 (sll $0 NOP) still counts as valid; only bubbles clear valid.
- Counters saturate at all-ones and never wrap.
- The stage never drives memory writes. The IM array is external and preloaded by the bench.
- There is no state machine beyond the RUN/HALT condition derived from the PC; HALT exits only via redirect or reset.

Test Plan:
- Reset then free run, IM[0..3]=A,B,C,D, no stall/redirect -> cycle1 IF/ID={A,4,1}, cycle4 IF/ID={D,16,1}, pc_o=16, fetch_cnt=4.
- Stall held 2 cycles while IF/ID={B,8,1} -> IF/ID and pc_o=8 unchanged for both cycles, stall_cnt=2, fetch_cnt unchanged; next edge loads C.
- redirect_i=1 with target_i=32'h0000_0013 while stall_i=1 -> pc_o=16 (low bits cleared), IF/ID bubble (valid=0, instr=0), redir_cnt=1, stall_cnt unchanged; next edge fetches IM[4] with pc4=20.
- IM_DEPTH=32, run to pc_o=128 -> halted_o=1, pc holds at 128, IF/ID bubble each cycle, fetch_cnt=32; then redirect to 8 -> halted_o=0, next edge loads IM[2].
- rst_i asserted for one edge mid-run with redirect_i=1 -> pc_o=RESET_PC, all outputs at reset values, redirect ignored.
- CNT_WIDTH=4, stall held 20 cycles -> stall_cnt_o saturates at 15.

Source files
------------

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory,
// loads the IF/ID pipeline register and keeps saturating performance counters.
// A redirect beats a stall, a stall beats the halt condition, and normal
// fetch happens only when none of them apply.
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned IM_DEPTH  = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [31:0]          target_i,
    output logic [31:0]          im_addr_o,
    input  logic [31:0]          im_data_i,
    output logic [31:0]          pc_o,
    output logic [31:0]          ifid_instr_o,
    output logic [31:0]          ifid_pc4_o,
    output logic                 ifid_valid_o,
    output logic                 halted_o,
    output logic [CNT_WIDTH-1:0] fetch_cnt_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] redir_cnt_o
);

    // First byte address past the loaded instruction image.
    localparam logic [31:0]          IM_BYTES = 32'(IM_DEPTH * 4);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [31:0]          pc_q,        pc_d;
    logic [31:0]          instr_q,     instr_d;
    logic [31:0]          pc4_q,       pc4_d;
    logic                 valid_q,     valid_d;
    logic [CNT_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] redir_cnt_q, redir_cnt_d;

    logic                 halted;
    logic [31:0]          pc_plus4;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign halted   = (pc_q >= IM_BYTES);
    assign pc_plus4 = pc_q + 32'd4;

    // Next-state selection in priority order: redirect, stall, halt, fetch.
    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a signal
        // unassigned, which would otherwise infer a latch.
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;

        if (redirect_i) begin
            // The branch is older than whatever is stalled, so it wins.
            pc_d        = {target_i[31:2], 2'b00};
            instr_d     = 32'h0;
            pc4_d       = 32'h0;
            valid_d     = 1'b0;
            redir_cnt_d = sat_inc(redir_cnt_q);
        end else if (stall_i) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else if (halted) begin
            instr_d     = 32'h0;
            pc4_d       = 32'h0;
            valid_d     = 1'b0;
        end else begin
            // A zero word is a real NOP and still counts as a valid fetch.
            pc_d        = pc_plus4;
            instr_d     = im_data_i;
            pc4_d       = pc_plus4;
            valid_d     = 1'b1;
            fetch_cnt_d = sat_inc(fetch_cnt_q);
        end
    end

    // State registers with synchronous reset; reset drops any pending redirect.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0;
            pc4_q       <= 32'h0;
            valid_q     <= 1'b0;
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign im_addr_o    = pc_q;
    assign pc_o         = pc_q;
    assign ifid_instr_o = instr_q;
    assign ifid_pc4_o   = pc4_q;
    assign ifid_valid_o = valid_q;
    assign halted_o     = halted;
    assign fetch_cnt_o  = fetch_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign redir_cnt_o  = redir_cnt_q;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Bench for pipe_if_stage: a cycle model predicts the post-edge state for
// every driven cycle, pushes it to a scoreboard queue and the entry is popped
// and compared once the edge has happened. Two instances share the stimulus:
// one with 16-bit counters and one with 4-bit counters to expose saturation.
module tb_pipe_if_stage;

    localparam int          IM_DEPTH = 32;
    localparam logic [31:0] IM_BYTES = 32'(IM_DEPTH * 4);
    localparam logic [31:0] W_A = 32'hA000_000A;
    localparam logic [31:0] W_B = 32'hB000_000B;
    localparam logic [31:0] W_C = 32'hC000_000C;
    localparam logic [31:0] W_D = 32'hD000_000D;
    localparam logic [31:0] W_OOR = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        int          fetch;
        int          stall;
        int          redir;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = 32'h0;
    logic [31:0] im_data, im_data4;
    logic [31:0] im_addr, pc, instr, pc4;
    logic        valid, halted;
    logic [15:0] fetch_cnt, stall_cnt, redir_cnt;
    logic [31:0] im_addr4, pc_4, instr_4, pc4_4;
    logic        valid_4, halted_4;
    logic [3:0]  fetch_cnt4, stall_cnt4, redir_cnt4;

    logic [31:0] im [0:IM_DEPTH-1];

    exp_t sb_q[$];
    exp_t m;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] im_read(input logic [31:0] a);
        return (a < IM_BYTES) ? im[a[6:2]] : W_OOR;
    endfunction

    assign im_data  = im_read(im_addr);
    assign im_data4 = im_read(im_addr4);

    pipe_if_stage #(.RESET_PC(32'h0), .IM_DEPTH(IM_DEPTH), .CNT_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
        .target_i(target), .im_addr_o(im_addr), .im_data_i(im_data),
        .pc_o(pc), .ifid_instr_o(instr), .ifid_pc4_o(pc4),
        .ifid_valid_o(valid), .halted_o(halted), .fetch_cnt_o(fetch_cnt),
        .stall_cnt_o(stall_cnt), .redir_cnt_o(redir_cnt)
    );

    pipe_if_stage #(.RESET_PC(32'h0), .IM_DEPTH(IM_DEPTH), .CNT_WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
        .target_i(target), .im_addr_o(im_addr4), .im_data_i(im_data4),
        .pc_o(pc_4), .ifid_instr_o(instr_4), .ifid_pc4_o(pc4_4),
        .ifid_valid_o(valid_4), .halted_o(halted_4), .fetch_cnt_o(fetch_cnt4),
        .stall_cnt_o(stall_cnt4), .redir_cnt_o(redir_cnt4)
    );

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Drive one cycle, predict its result, then compare after the edge.
    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; redirect = d; target = t;
        if (r) begin
            m.pc = 32'h0; m.instr = 0; m.pc4 = 0; m.valid = 0;
            m.fetch = 0; m.stall = 0; m.redir = 0;
        end else if (d) begin
            m.pc = {t[31:2], 2'b00}; m.instr = 0; m.pc4 = 0; m.valid = 0;
            m.redir++;
        end else if (s) begin
            m.stall++;
        end else if (m.pc >= IM_BYTES) begin
            m.instr = 0; m.pc4 = 0; m.valid = 0;
        end else begin
            m.instr = im_read(m.pc); m.pc4 = m.pc + 4; m.valid = 1;
            m.pc = m.pc + 4; m.fetch++;
        end
        m.halted = (m.pc >= IM_BYTES);
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if (pc !== e.pc || im_addr !== e.pc || halted !== e.halted) begin
                n_errors++;
                $display("FAIL pc t=%0t got pc=%h addr=%h halt=%b want pc=%h halt=%b",
                         $time, pc, im_addr, halted, e.pc, e.halted);
            end
            n_checks++;
            if (instr !== e.instr || pc4 !== e.pc4 || valid !== e.valid) begin
                n_errors++;
                $display("FAIL ifid t=%0t got %h/%h/%b want %h/%h/%b",
                         $time, instr, pc4, valid, e.instr, e.pc4, e.valid);
            end
            n_checks++;
            if (fetch_cnt !== 16'(sat(e.fetch, 65535)) || stall_cnt !== 16'(sat(e.stall, 65535)) ||
                redir_cnt !== 16'(sat(e.redir, 65535))) begin
                n_errors++;
                $display("FAIL cnt16 t=%0t got f=%0d s=%0d r=%0d want f=%0d s=%0d r=%0d",
                         $time, fetch_cnt, stall_cnt, redir_cnt, e.fetch, e.stall, e.redir);
            end
            n_checks++;
            if (fetch_cnt4 !== 4'(sat(e.fetch, 15)) || stall_cnt4 !== 4'(sat(e.stall, 15)) ||
                redir_cnt4 !== 4'(sat(e.redir, 15)) || pc_4 !== e.pc || instr_4 !== e.instr) begin
                n_errors++;
                $display("FAIL dut4 t=%0t got f=%0d s=%0d r=%0d pc=%h want f=%0d s=%0d r=%0d pc=%h",
                         $time, fetch_cnt4, stall_cnt4, redir_cnt4, pc_4,
                         sat(e.fetch, 15), sat(e.stall, 15), sat(e.redir, 15), e.pc);
            end
        end
    endtask

    task automatic test_reset();
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        n_checks++;
        if (pc !== 32'h0 || valid !== 1'b0 || instr !== 32'h0 || pc4 !== 32'h0 ||
            halted !== 1'b0 || fetch_cnt !== 16'd0 || stall_cnt !== 16'd0 || redir_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_state got pc=%h v=%b i=%h p4=%h h=%b f=%0d s=%0d r=%0d want all zero",
                     pc, valid, instr, pc4, halted, fetch_cnt, stall_cnt, redir_cnt);
        end
    endtask

    task automatic test_free_run();
        step(1, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        n_checks++;
        if (instr !== W_A || pc4 !== 32'd4 || valid !== 1'b1) begin
            n_errors++;
            $display("FAIL free_run_first got %h/%h/%b want %h/4/1", instr, pc4, valid, W_A);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0);
        n_checks++;
        if (instr !== W_D || pc4 !== 32'd16 || pc !== 32'd16 || fetch_cnt !== 16'd4) begin
            n_errors++;
            $display("FAIL free_run_fourth got i=%h p4=%h pc=%h f=%0d want i=%h p4=16 pc=16 f=4",
                     instr, pc4, pc, fetch_cnt, W_D);
        end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 32'h0);
            n_checks++;
            if (instr !== W_B || pc4 !== 32'd8 || pc !== 32'd8 || fetch_cnt !== 16'd2) begin
                n_errors++;
                $display("FAIL stall_hold got i=%h p4=%h pc=%h f=%0d want i=%h p4=8 pc=8 f=2",
                         instr, pc4, pc, fetch_cnt, W_B);
            end
        end
        n_checks++;
        if (stall_cnt !== 16'd2) begin
            n_errors++;
            $display("FAIL stall_count got %0d want 2", stall_cnt);
        end
        step(0, 0, 0, 32'h0);
        n_checks++;
        if (instr !== W_C || pc4 !== 32'd12) begin
            n_errors++;
            $display("FAIL stall_release got %h/%h want %h/12", instr, pc4, W_C);
        end
    endtask

    task automatic test_redirect_over_stall();
        step(0, 1, 1, 32'h0000_0013);
        n_checks++;
        if (pc !== 32'd16 || valid !== 1'b0 || instr !== 32'h0 ||
            redir_cnt !== 16'd1 || stall_cnt !== 16'd2) begin
            n_errors++;
            $display("FAIL redirect got pc=%h v=%b i=%h r=%0d s=%0d want pc=10 v=0 i=0 r=1 s=2",
                     pc, valid, instr, redir_cnt, stall_cnt);
        end
        step(0, 0, 0, 32'h0);
        n_checks++;
        if (instr !== im[4] || pc4 !== 32'd20 || valid !== 1'b1) begin
            n_errors++;
            $display("FAIL redirect_next got %h/%h/%b want %h/20/1", instr, pc4, valid, im[4]);
        end
        step(0, 0, 0, 32'h0);
        n_checks++;
        if (instr !== 32'h0 || valid !== 1'b1 || pc4 !== 32'd24) begin
            n_errors++;
            $display("FAIL nop_valid got %h/%h/%b want 0/24/1", instr, pc4, valid);
        end
    endtask

    task automatic test_halt();
        step(1, 0, 0, 32'h0);
        for (int i = 0; i < IM_DEPTH; i++) step(0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 32'h0);
            n_checks++;
            if (halted !== 1'b1 || pc !== 32'd128 || valid !== 1'b0 ||
                instr !== 32'h0 || fetch_cnt !== 16'd32) begin
                n_errors++;
                $display("FAIL halt_hold got h=%b pc=%h v=%b i=%h f=%0d want h=1 pc=80 v=0 i=0 f=32",
                         halted, pc, valid, instr, fetch_cnt);
            end
        end
        n_checks++;
        if (fetch_cnt4 !== 4'd15) begin
            n_errors++;
            $display("FAIL fetch_sat4 got %0d want 15", fetch_cnt4);
        end
        step(0, 0, 1, 32'd8);
        n_checks++;
        if (halted !== 1'b0 || pc !== 32'd8) begin
            n_errors++;
            $display("FAIL halt_exit got h=%b pc=%h want h=0 pc=8", halted, pc);
        end
        step(0, 0, 0, 32'h0);
        n_checks++;
        if (instr !== W_C || pc4 !== 32'd12 || valid !== 1'b1) begin
            n_errors++;
            $display("FAIL halt_exit_fetch got %h/%h/%b want %h/12/1", instr, pc4, valid, W_C);
        end
    endtask

    task automatic test_reset_mid_run();
        step(0, 0, 0, 32'h0);
        step(1, 0, 1, 32'h0000_0040);
        n_checks++;
        if (pc !== 32'h0 || valid !== 1'b0 || instr !== 32'h0 || pc4 !== 32'h0 ||
            fetch_cnt !== 16'd0 || stall_cnt !== 16'd0 || redir_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_mid_run got pc=%h v=%b i=%h f=%0d s=%0d r=%0d want all zero",
                     pc, valid, instr, fetch_cnt, stall_cnt, redir_cnt);
        end
    endtask

    task automatic test_saturation();
        step(0, 0, 0, 32'h0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 32'h0);
        n_checks++;
        if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'd20) begin
            n_errors++;
            $display("FAIL stall_sat got s4=%0d s16=%0d want s4=15 s16=20", stall_cnt4, stall_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < IM_DEPTH; i++) im[i] = 32'h1000_0000 + 32'(i * 32'h0101);
        im[0] = W_A; im[1] = W_B; im[2] = W_C; im[3] = W_D;
        im[5] = 32'h0;
        m = '{pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, halted: 1'b0,
              fetch: 0, stall: 0, redir: 0};

        test_reset();
        test_free_run();
        test_stall();
        test_redirect_over_stall();
        test_halt();
        test_reset_mid_run();
        test_saturation();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
